// File: rtl/dram_slot_sequencer_if.sv
// rtl/dram_slot_sequencer_if.sv - bus bundle between the DRAM slot sequencer and its host
// Signals:
//   video request : vid_en, vid_addr_load, vid_addr_start
//   cpu request   : cpu_sel, cpu_rw, cpu_addr
//   clocks/status : E, Q, phase
//   dram pins     : nRAS, nCAS, nWE, ma
//   strobes       : vid_latch, cpu_latch
// Modports: master = host side (drives requests), slave = sequencer side.
interface dram_slot_sequencer_if #(
    parameter int AW = 14
);
    logic          vid_en;
    logic          vid_addr_load;
    logic [AW-1:0] vid_addr_start;
    logic          cpu_sel;
    logic          cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic          E;
    logic          Q;
    logic          nRAS;
    logic          nCAS;
    logic          nWE;
    logic [AW/2-1:0] ma;
    logic          vid_latch;
    logic          cpu_latch;
    logic [3:0]    phase;

    modport master (
        output vid_en, vid_addr_load, vid_addr_start, cpu_sel, cpu_rw, cpu_addr,
        input  E, Q, nRAS, nCAS, nWE, ma, vid_latch, cpu_latch, phase
    );

    modport slave (
        input  vid_en, vid_addr_load, vid_addr_start, cpu_sel, cpu_rw, cpu_addr,
        output E, Q, nRAS, nCAS, nWE, ma, vid_latch, cpu_latch, phase
    );
endinterface

// File: rtl/dram_slot_sequencer.sv
// rtl/dram_slot_sequencer.sv - video/CPU DRAM slot sequencer with 6809 E/Q generation
// Ports:
//   PIN_H16 : 16 MHz master clock, rising edge
//   PIN_58  : asynchronous active-low reset
//   bus     : slave side of dram_slot_sequencer_if (requests in, DRAM pins/strobes/clocks out)
// Each CPU cycle is 16 master clocks: phases 0..7 are the video slot (fetch or
// RAS-only refresh), phases 8..15 the CPU slot. Every output is a register loaded
// with the value belonging to the phase that starts at that clock edge.
module dram_slot_sequencer #(
    parameter int AW      = 14,
    parameter int RW_BITS = 7
) (
    input  logic PIN_H16,
    input  logic PIN_58,
    dram_slot_sequencer_if.slave bus
);
    localparam int HW = AW / 2;

    typedef enum logic {SLOT_VIDEO, SLOT_CPU} slot_t;

    slot_t               slot_q, slot_d;
    logic [3:0]          phase_q, phase_d;
    logic                fetch_q, fetch_d;
    logic                csel_q, csel_d;
    logic                crw_q, crw_d;
    logic [AW-1:0]       caddr_q, caddr_d;
    logic [AW-1:0]       vaddr_q, vaddr_d;
    logic [RW_BITS-1:0]  rcnt_q, rcnt_d;
    logic                e_q, e_d, q_q, q_d;
    logic                ras_q, ras_d, cas_q, cas_d, we_q, we_d;
    logic [HW-1:0]       ma_q, ma_d;
    logic                vlat_q, vlat_d, clat_q, clat_d;

    always_ff @(posedge PIN_H16 or negedge PIN_58) begin
        if (!PIN_58) begin
            slot_q  <= SLOT_VIDEO;
            phase_q <= 4'd0;
            fetch_q <= 1'b0;
            csel_q  <= 1'b0;
            crw_q   <= 1'b1;
            caddr_q <= '0;
            vaddr_q <= '0;
            rcnt_q  <= '0;
            e_q     <= 1'b0;
            q_q     <= 1'b0;
            ras_q   <= 1'b1;
            cas_q   <= 1'b1;
            we_q    <= 1'b1;
            ma_q    <= '0;
            vlat_q  <= 1'b0;
            clat_q  <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            phase_q <= phase_d;
            fetch_q <= fetch_d;
            csel_q  <= csel_d;
            crw_q   <= crw_d;
            caddr_q <= caddr_d;
            vaddr_q <= vaddr_d;
            rcnt_q  <= rcnt_d;
            e_q     <= e_d;
            q_q     <= q_d;
            ras_q   <= ras_d;
            cas_q   <= cas_d;
            we_q    <= we_d;
            ma_q    <= ma_d;
            vlat_q  <= vlat_d;
            clat_q  <= clat_d;
        end
    end

    always_comb begin
        phase_d = phase_q + 4'd1;
        fetch_d = fetch_q;
        csel_d  = csel_q;
        crw_d   = crw_q;
        caddr_d = caddr_q;
        vaddr_d = vaddr_q;
        rcnt_d  = rcnt_q;

        // Video mode is latched on the edge that enters phase 0.
        if (phase_q == 4'd15) begin
            fetch_d = bus.vid_en;
        end

        // Edge leaving phase 7: video update point and CPU request capture.
        if (phase_q == 4'd7) begin
            csel_d  = bus.cpu_sel;
            crw_d   = bus.cpu_rw;
            caddr_d = bus.cpu_addr;
            if (bus.vid_addr_load) begin
                vaddr_d = bus.vid_addr_start;
            end else if (fetch_q) begin
                vaddr_d = vaddr_q + AW'(1);
            end
            if (!fetch_q) begin
                rcnt_d = rcnt_q + RW_BITS'(1);
            end
        end

        slot_d = phase_d[3] ? SLOT_CPU : SLOT_VIDEO;
        e_d    = phase_d[3];
        q_d    = (phase_d >= 4'd4) && (phase_d <= 4'd11);
        ras_d  = 1'b1;
        cas_d  = 1'b1;
        we_d   = 1'b1;
        ma_d   = ma_q;
        vlat_d = 1'b0;
        clat_d = 1'b0;

        case (slot_d)
            SLOT_VIDEO: begin
                ras_d = !((phase_d >= 4'd1) && (phase_d <= 4'd5));
                if (fetch_d) begin
                    cas_d  = !((phase_d >= 4'd3) && (phase_d <= 4'd5));
                    ma_d   = (phase_d <= 4'd2) ? vaddr_d[HW-1:0] : vaddr_d[AW-1:HW];
                    vlat_d = (phase_d == 4'd5);
                end else begin
                    ma_d = rcnt_d;
                end
            end
            SLOT_CPU: begin
                // Unselected slot leaves ma at the phase-7 value.
                if (csel_d) begin
                    ras_d = !((phase_d >= 4'd9) && (phase_d <= 4'd13));
                    cas_d = !((phase_d >= 4'd11) && (phase_d <= 4'd13));
                    ma_d  = (phase_d <= 4'd10) ? caddr_d[HW-1:0] : caddr_d[AW-1:HW];
                    if (crw_d) begin
                        clat_d = (phase_d == 4'd13);
                    end else begin
                        we_d = !((phase_d >= 4'd10) && (phase_d <= 4'd13));
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.E         = e_q;
    assign bus.Q         = q_q;
    assign bus.nRAS      = ras_q;
    assign bus.nCAS      = cas_q;
    assign bus.nWE       = we_q;
    assign bus.ma        = ma_q;
    assign bus.vid_latch = vlat_q;
    assign bus.cpu_latch = clat_q;
    assign bus.phase     = phase_q;
endmodule
